// File: rtl/vga_sync_if.sv
// Video timing bundle from the sync generator to the pixel logic.
// The master drives the ticks, syncs and coordinates; the slave consumes them.
interface vga_sync_if;
    logic       p_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_end;

    modport master (
        output p_tick, hsync, vsync, video_on,
        output pixel_x, pixel_y, frame_end
    );

    modport slave (
        input p_tick, hsync, vsync, video_on,
        input pixel_x, pixel_y, frame_end
    );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: turns clk_div rising edges into pixel ticks and
// walks horizontal/vertical counters to produce sync, blanking and coords.
module vga_sync #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_div,
    vga_sync_if.master  vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       clk_div_q;
    logic       tick;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hsync_q;
    logic       vsync_q;

    assign tick = clk_div & ~clk_div_q;

    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (tick) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                if (v_count == V_LAST)
                    v_next = '0;
                else
                    v_next = v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
            end
        end
    end

    // Syncs load from the next counts so they line up with pixel_x/pixel_y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_div_q <= 1'b0;
            h_count   <= '0;
            v_count   <= '0;
            hsync_q   <= ~SYNC_ACTIVE;
            vsync_q   <= ~SYNC_ACTIVE;
        end else begin
            clk_div_q <= clk_div;
            h_count   <= h_next;
            v_count   <= v_next;
            hsync_q   <= (h_next >= HS_LO && h_next <= HS_HI)
                         ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q   <= (v_next >= VS_LO && v_next <= VS_HI)
                         ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    assign vga.p_tick    = tick;
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.pixel_x   = h_count;
    assign vga.pixel_y   = v_count;
    assign vga.video_on  = (h_count < H_VIS) && (v_count < V_VIS);
    assign vga.frame_end = tick && (h_count == H_LAST) && (v_count == V_LAST);
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a shrunk-timing instance under random clk_div and a
// full 640x480 instance under a real divide-by-4 waveform, both vs. a tick model.
module tb_vga_sync;
    // Small instance geometry: H_TOTAL=15, V_TOTAL=8.
    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 1;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;
    localparam int DHT = 800, DVT = 525;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_s, rst_d;
    logic clk_div_s, clk_div_d;

    int total = 0;
    int bad = 0;

    vga_sync_if vif_s ();
    vga_sync_if vif_d ();

    vga_sync #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_ACTIVE(1'b0)
    ) dut_s (
        .clk(clk), .reset(rst_s), .clk_div(clk_div_s), .vga(vif_s)
    );

    vga_sync dut_d (
        .clk(clk), .reset(rst_d), .clk_div(clk_div_d), .vga(vif_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Position after n ticks since reset, from the timing rules alone.
    function automatic exp_t expect_at(input int n, input int ht,
                                       input int vt, input int hv,
                                       input int hf, input int hs,
                                       input int vv, input int vf,
                                       input int vs);
        exp_t e;
        int h, v;
        h = n % ht;
        v = (n / ht) % vt;
        e.x    = 10'(h);
        e.y    = 10'(v);
        e.hs   = (h >= hv + hf && h < hv + hf + hs) ? 1'b0 : 1'b1;
        e.vs   = (v >= vv + vf && v < vv + vf + vs) ? 1'b0 : 1'b1;
        e.von  = (h < hv) && (v < vv);
        e.last = (h == ht - 1) && (v == vt - 1);
        return e;
    endfunction

    int   n_s, n_d;
    logic prev_s, prev_d;

    always @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            n_s    <= 0;
            prev_s <= 1'b0;
        end else begin
            if (clk_div_s && !prev_s)
                n_s <= (n_s + 1) % (SHT * SVT);
            prev_s <= clk_div_s;
        end
    end

    always @(posedge clk or posedge rst_d) begin
        if (rst_d) begin
            n_d    <= 0;
            prev_d <= 1'b0;
        end else begin
            if (clk_div_d && !prev_d)
                n_d <= (n_d + 1) % (DHT * DVT);
            prev_d <= clk_div_d;
        end
    end

    int cyc = 0;
    int last_tick_d = -1;
    int hs_low_line0 = 0;
    int von_line1 = 0;
    int fe_cnt_s = 0;
    bit run_cmp = 1'b0;

    always @(negedge clk) begin
        exp_t es, ed;
        logic tk_s, tk_d;
        cyc++;
        if (run_cmp) begin
            es = expect_at(n_s, SHT, SVT, SHV, SHF, SHS, SVV, SVF, SVS);
            ed = expect_at(n_d, DHT, DVT, 640, 16, 96, 480, 10, 2);
            tk_s = clk_div_s & ~prev_s;
            tk_d = clk_div_d & ~prev_d;
            chk("s_x", 32'(vif_s.pixel_x), 32'(es.x));
            chk("s_y", 32'(vif_s.pixel_y), 32'(es.y));
            chk("s_hsync", 32'(vif_s.hsync), 32'(es.hs));
            chk("s_vsync", 32'(vif_s.vsync), 32'(es.vs));
            chk("s_video_on", 32'(vif_s.video_on), 32'(es.von));
            chk("s_p_tick", 32'(vif_s.p_tick), 32'(tk_s));
            chk("s_frame_end", 32'(vif_s.frame_end),
                32'(tk_s & es.last));
            chk("d_x", 32'(vif_d.pixel_x), 32'(ed.x));
            chk("d_y", 32'(vif_d.pixel_y), 32'(ed.y));
            chk("d_hsync", 32'(vif_d.hsync), 32'(ed.hs));
            chk("d_vsync", 32'(vif_d.vsync), 32'(ed.vs));
            chk("d_video_on", 32'(vif_d.video_on), 32'(ed.von));
            chk("d_p_tick", 32'(vif_d.p_tick), 32'(tk_d));
            chk("d_frame_end", 32'(vif_d.frame_end),
                32'(tk_d & ed.last));
            if (vif_s.frame_end === 1'b1)
                fe_cnt_s++;
            if (!rst_d) begin
                if (vif_d.p_tick === 1'b1) begin
                    if (last_tick_d >= 0)
                        chk("d_tick_gap", 32'(cyc - last_tick_d), 32'd4);
                    last_tick_d = cyc;
                end
                if (vif_d.pixel_y == 10'd0 && vif_d.hsync == 1'b0)
                    hs_low_line0++;
                if (vif_d.pixel_y == 10'd1 && vif_d.video_on == 1'b1)
                    von_line1++;
            end
        end
    end

    task automatic drive_default(input int cycles);
        int ph = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            clk_div_d = (ph >= 2);
        end
    endtask

    task automatic drive_small();
        logic [9:0] hold_x, hold_y;
        logic       hold_hs, hold_vs;
        bit         found;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1 clk_div_s = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 clk_div_s = 1'b0;
        @(negedge clk);
        hold_x  = vif_s.pixel_x;
        hold_y  = vif_s.pixel_y;
        hold_hs = vif_s.hsync;
        hold_vs = vif_s.vsync;
        repeat (100) @(negedge clk);
        chk("stall_x", 32'(vif_s.pixel_x), 32'(hold_x));
        chk("stall_y", 32'(vif_s.pixel_y), 32'(hold_y));
        chk("stall_hsync", 32'(vif_s.hsync), 32'(hold_hs));
        chk("stall_vsync", 32'(vif_s.vsync), 32'(hold_vs));
        @(posedge clk);
        #1 clk_div_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("resume_x", 32'(vif_s.pixel_x), 32'((hold_x + 1) % SHT));

        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (vif_s.hsync == 1'b0 && vif_s.vsync == 1'b0)
                found = 1'b1;
            else begin
                @(posedge clk);
                #1 clk_div_s = 1'($urandom_range(0, 1));
            end
        end
        chk("sync_low_found", 32'(found), 32'd1);
        #1 rst_s = 1'b1;
        #1;
        chk("mid_rst_x", 32'(vif_s.pixel_x), 32'd0);
        chk("mid_rst_y", 32'(vif_s.pixel_y), 32'd0);
        chk("mid_rst_hsync", 32'(vif_s.hsync), 32'd1);
        chk("mid_rst_vsync", 32'(vif_s.vsync), 32'd1);
        chk("mid_rst_video_on", 32'(vif_s.video_on), 32'd1);
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        clk_div_s = 1'b0;
        @(posedge clk);
        #1 clk_div_s = 1'b1;
        @(negedge clk);
        chk("rel_p_tick", 32'(vif_s.p_tick), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rel_x", 32'(vif_s.pixel_x), 32'd1);
        chk("rel_y", 32'(vif_s.pixel_y), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1 clk_div_s = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        rst_s = 1'b1;
        rst_d = 1'b1;
        clk_div_s = 1'b0;
        clk_div_d = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", 32'(vif_d.pixel_x), 32'd0);
        chk("rst_y", 32'(vif_d.pixel_y), 32'd0);
        chk("rst_hsync", 32'(vif_d.hsync), 32'd1);
        chk("rst_vsync", 32'(vif_d.vsync), 32'd1);
        chk("rst_video_on", 32'(vif_d.video_on), 32'd1);
        chk("rst_p_tick", 32'(vif_d.p_tick), 32'd0);
        chk("rst_frame_end", 32'(vif_d.frame_end), 32'd0);
        run_cmp = 1'b1;
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        rst_d = 1'b0;
        fork
            drive_default(800 * 4 * 2 + 400);
            drive_small();
        join
        @(negedge clk);
        chk("d_hsync_low_line0", 32'(hs_low_line0), 32'd384);
        chk("d_video_on_line1", 32'(von_line1), 32'd2560);
        chk("d_reached_line2", 32'(vif_d.pixel_y), 32'd2);
        chk("s_frame_end_seen", 32'(fe_cnt_s > 0), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
